// File: rtl/pc_fetch.sv
// Instruction fetch unit: one outstanding fetch, holds the returned word until
// downstream consumes it, then computes the next PC from jump/branch controls.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [5:0]  o_opcode,
  output logic        o_instr_valid,
  input  logic        i_stall,
  input  logic        i_branch_beq,
  input  logic        i_branch_bne,
  input  logic        i_jump,
  input  logic        i_zero,
  output logic [31:0] o_pc,
  output logic        o_illegal,
  output logic [15:0] o_issue_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned OP_W  = 6;

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             vld_q, vld_d;
  logic             ill_q, ill_d;

  logic [XLEN-1:0]  pc4;
  logic [XLEN-1:0]  br_off;
  logic [XLEN-1:0]  next_pc;
  logic [OP_W-1:0]  opcode;
  logic             opcode_legal;
  logic             br_taken;

  assign opcode = instr_q[31:26];

  // Opcode legality and next-PC selection for the held instruction
  always_comb begin
    opcode_legal = 1'b0;
    case (opcode)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000,
      6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b000010:
        opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase

    pc4      = XLEN'(pc_q + 32'd4);
    br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    br_taken = (i_branch_beq & i_zero) | (i_branch_bne & ~i_zero);
    next_pc  = pc4;
    if (opcode_legal) begin
      if (i_jump) begin
        next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
      end else if (br_taken) begin
        next_pc = XLEN'(pc4 + br_off);
      end
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    vld_d   = vld_q;
    ill_d   = 1'b0;

    case (state_q)
      FETCH: begin
        req_d = 1'b1;
        // Only a response to our own live request is accepted
        if (req_q && i_imem_valid) begin
          instr_d = i_imem_rdata;
          vld_d   = 1'b1;
          req_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        req_d = 1'b0;
        if (!i_stall) begin
          pc_d    = next_pc;
          cnt_d   = CNT_W'(cnt_q + 16'd1);
          ill_d   = ~opcode_legal;
          vld_d   = 1'b0;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      ill_q   <= ill_d;
    end
  end

  assign o_imem_req    = req_q;
  assign o_imem_addr   = pc_q;
  assign o_pc          = pc_q;
  assign o_instr       = instr_q;
  assign o_opcode      = opcode;
  assign o_instr_valid = vld_q;
  assign o_illegal     = ill_q;
  assign o_issue_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a low-address instance for sequencing/branches
// and a second instance reset into the upper region for the jump case.
module tb_pc_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic [5:0]  o_opcode;
  logic        o_instr_valid;
  logic        i_stall;
  logic        i_branch_beq, i_branch_bne, i_jump, i_zero;
  logic [31:0] o_pc;
  logic        o_illegal;
  logic [15:0] o_issue_count;

  logic        h_req, h_valid, h_instr_valid, h_illegal, h_jump;
  logic [31:0] h_addr, h_rdata, h_instr, h_pc;
  logic [5:0]  h_opcode;
  logic [15:0] h_count;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  pc_fetch dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_valid(i_imem_valid), .i_imem_rdata(i_imem_rdata),
    .o_instr(o_instr), .o_opcode(o_opcode), .o_instr_valid(o_instr_valid),
    .i_stall(i_stall), .i_branch_beq(i_branch_beq), .i_branch_bne(i_branch_bne),
    .i_jump(i_jump), .i_zero(i_zero), .o_pc(o_pc), .o_illegal(o_illegal),
    .o_issue_count(o_issue_count)
  );

  pc_fetch #(.RESET_PC(32'h4000_0010)) dut_hi (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(h_req), .o_imem_addr(h_addr),
    .i_imem_valid(h_valid), .i_imem_rdata(h_rdata),
    .o_instr(h_instr), .o_opcode(h_opcode), .o_instr_valid(h_instr_valid),
    .i_stall(1'b0), .i_branch_beq(1'b0), .i_branch_bne(1'b0),
    .i_jump(h_jump), .i_zero(1'b0), .o_pc(h_pc), .o_illegal(h_illegal),
    .o_issue_count(h_count)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Wait for the request, respond one cycle later, check the captured word
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word);
    int n;
    n = 0;
    while (o_imem_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chkb("fetch_req", o_imem_req, 1'b1);
    chk("fetch_addr", o_imem_addr, exp_addr);
    tick();
    chkb("req_held", o_imem_req, 1'b1);
    chk("addr_held", o_imem_addr, exp_addr);
    i_imem_valid = 1'b1;
    i_imem_rdata = word;
    tick();
    i_imem_valid = 1'b0;
    i_imem_rdata = 32'hDEAD_BEEF;
    chkb("instr_valid", o_instr_valid, 1'b1);
    chk("instr", o_instr, word);
    chk("opcode", 32'(o_opcode), 32'(word[31:26]));
    chk("pc", o_pc, exp_addr);
    chkb("issue_req_low", o_imem_req, 1'b0);
  endtask

  // Present controls for one edge with stall low, then check the consume
  task automatic consume(input logic beq, input logic bne, input logic jmp, input logic zero,
                         input logic [31:0] exp_next, input logic [15:0] exp_cnt,
                         input logic exp_ill);
    i_branch_beq = beq;
    i_branch_bne = bne;
    i_jump       = jmp;
    i_zero       = zero;
    i_stall      = 1'b0;
    tick();
    i_stall      = 1'b1;
    i_branch_beq = 1'b0;
    i_branch_bne = 1'b0;
    i_jump       = 1'b0;
    i_zero       = 1'b0;
    chk("next_addr", o_imem_addr, exp_next);
    chk("issue_count", 32'(o_issue_count), 32'(exp_cnt));
    chkb("illegal", o_illegal, exp_ill);
    chkb("valid_cleared", o_instr_valid, 1'b0);
    chkb("refetch_req", o_imem_req, 1'b1);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_imem_valid = 1'b0;
    i_imem_rdata = 32'h0;
    i_stall = 1'b1;
    i_branch_beq = 1'b0;
    i_branch_bne = 1'b0;
    i_jump = 1'b0;
    i_zero = 1'b0;
    h_valid = 1'b0;
    h_rdata = 32'h0;
    h_jump = 1'b0;
    #1;
    chkb("rst_req", o_imem_req, 1'b0);
    chkb("rst_valid", o_instr_valid, 1'b0);
    chkb("rst_illegal", o_illegal, 1'b0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_count", 32'(o_issue_count), 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_addr", o_imem_addr, 32'h0);
    tick();
    tick();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    chkb("first_req", o_imem_req, 1'b1);
    chk("first_addr", o_imem_addr, 32'h0);

    // addi-type word, then sequential next address
    fetch(32'h0, 32'h2008_0005);
    chk("addi_opcode", 32'(o_opcode), 32'(6'b001000));
    consume(1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 16'd1, 1'b0);

    // J to 0x10, BEQ taken -> 0x20
    fetch(32'h4, 32'h0800_0004);
    consume(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 16'd2, 1'b0);
    fetch(32'h10, 32'h1000_0003);
    consume(1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 16'd3, 1'b0);

    // back to 0x10, BEQ not taken -> 0x14
    fetch(32'h20, 32'h0800_0004);
    consume(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 16'd4, 1'b0);
    fetch(32'h10, 32'h1000_0003);
    consume(1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 16'd5, 1'b0);

    // J to 0x8, BNE imm -1 loops on itself, then falls through when zero
    fetch(32'h14, 32'h0800_0002);
    consume(1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 16'd6, 1'b0);
    fetch(32'h8, 32'h1400_FFFF);
    consume(1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 16'd7, 1'b0);
    fetch(32'h8, 32'h1400_FFFF);
    consume(1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 16'd8, 1'b0);
    fetch(32'h8, 32'h1400_FFFF);
    consume(1'b0, 1'b1, 1'b0, 1'b1, 32'hC, 16'd9, 1'b0);

    // J to 0, BEQ imm -2 wraps backwards to 0xFFFF_FFFC
    fetch(32'hC, 32'h0800_0000);
    consume(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 16'd10, 1'b0);
    fetch(32'h0, 32'h1000_FFFE);
    consume(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 16'd11, 1'b0);

    // Illegal opcode held under stall, then consumed with jump asserted
    fetch(32'hFFFF_FFFC, 32'hFC00_0123);
    for (int k = 0; k < 3; k++) begin
      tick();
      chkb("stall_req", o_imem_req, 1'b0);
      chkb("stall_valid", o_instr_valid, 1'b1);
      chk("stall_instr", o_instr, 32'hFC00_0123);
      chk("stall_pc", o_pc, 32'hFFFF_FFFC);
      chk("stall_count", 32'(o_issue_count), 32'd11);
    end
    consume(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 16'd12, 1'b1);
    tick();
    chkb("illegal_pulse_end", o_illegal, 1'b0);

    // Asynchronous reset while a request is outstanding
    #2;
    i_rst_n = 1'b0;
    #1;
    chkb("midrst_req", o_imem_req, 1'b0);
    chk("midrst_addr", o_imem_addr, 32'h0);
    chk("midrst_count", 32'(o_issue_count), 32'h0);
    chk("midrst_hi_addr", h_addr, 32'h4000_0010);

    // A stale response straddling release must not be captured
    i_imem_valid = 1'b1;
    i_imem_rdata = 32'h1234_5678;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    i_imem_valid = 1'b0;
    chkb("late_valid_ignored", o_instr_valid, 1'b0);
    chkb("rerelease_req", o_imem_req, 1'b1);
    chk("rerelease_addr", o_imem_addr, 32'h0);

    // Jump within the upper 256MB region
    chkb("hi_req", h_req, 1'b1);
    chk("hi_addr", h_addr, 32'h4000_0010);
    tick();
    h_valid = 1'b1;
    h_rdata = 32'h0800_0100;
    tick();
    h_valid = 1'b0;
    chkb("hi_valid", h_instr_valid, 1'b1);
    chk("hi_opcode", 32'(h_opcode), 32'(6'b000010));
    h_jump = 1'b1;
    tick();
    h_jump = 1'b0;
    chk("hi_jump_addr", h_addr, 32'h4000_0400);
    chk("hi_count", 32'(h_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the word-aligned fetch address loaded on reset.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port i_clk  input  1  rising-edge clock.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port o_imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port o_imem_addr  output  32  byte address of the fetch, bits [1:0] always 0.
REQ-007 SHALL have port i_imem_valid  input  1  read data valid, at least 1 cycle after the request.
REQ-008 SHALL have port i_imem_rdata  input  32  instruction word.
REQ-009 SHALL have port o_instr  output  32  held instruction word.
REQ-010 SHALL have port o_opcode  output  6  o_instr[31:26], driven to the control decoder.
REQ-011 SHALL have port o_instr_valid  output  1  o_instr and o_pc are valid.
REQ-012 SHALL have port i_stall  input  1  downstream not accepting the instruction.
REQ-013 SHALL have ports i_branch_beq, i_branch_bne, i_jump  input  1 each  decoded control for o_opcode.
REQ-014 SHALL have port i_zero  input  1  ALU zero flag for the held instruction.
REQ-015 SHALL have port o_pc  output  32  address of the held instruction.
REQ-016 SHALL have port o_illegal  output  1  one-cycle pulse when an illegal opcode is consumed.
REQ-017 SHALL have port o_issue_count  output  16  count of consumed instructions.

Function
REQ-018 SHALL implement states FETCH (request outstanding) and ISSUE (instruction held).
REQ-019 FETCH SHALL assert o_imem_req with o_imem_addr = PC, held stable until i_imem_valid.
REQ-020 FETCH with i_imem_valid SHALL capture i_imem_rdata into o_instr and move to ISSUE, so o_instr_valid=1 the next cycle.
REQ-021 ISSUE SHALL deassert o_imem_req and ignore i_imem_valid.
REQ-022 ISSUE with i_stall=1 SHALL hold o_instr, o_pc, o_instr_valid and the PC unchanged.
REQ-023 ISSUE with i_stall=0 SHALL consume: load PC with next_pc, increment o_issue_count, and return to FETCH.
REQ-024 Legal opcodes SHALL be 000000, 100011, 101011, 000100, 000101, 001000, 001010, 001100, 001101, 001110 and 000010.
REQ-025 For a legal opcode, next_pc SHALL be chosen by priority:
  - i_jump: {pc4[31:28], instr[25:0], 2'b00}
  - taken branch (i_branch_beq & i_zero, or i_branch_bne & ~i_zero): pc4 + (sign-extended instr[15:0] << 2)
  - otherwise: pc4
  where pc4 = PC + 4.
REQ-026 For an illegal opcode, the unit SHALL ignore the control inputs, take next_pc = pc4 and pulse o_illegal on the consuming cycle.
REQ-027 All PC arithmetic SHALL be 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 wraps to 0.
REQ-028 o_issue_count SHALL wrap from 16'hFFFF to 0.
REQ-029 Best-case throughput SHALL be one instruction per 3 cycles (FETCH, response, ISSUE); there is no speculative prefetch.

Reset
REQ-030 i_rst_n=0 SHALL immediately set:
  - o_imem_req=0, o_instr_valid=0, o_illegal=0
  - o_instr=0, o_issue_count=0
  - PC = o_pc = o_imem_addr = RESET_PC
  and the state SHALL become FETCH.
REQ-031 Reset mid-request SHALL abandon the outstanding fetch, and a late i_imem_valid before the new request SHALL be ignored.
REQ-032 On the first clock edge after deassertion, o_imem_req SHALL be 1 with o_imem_addr=RESET_PC.

Verification
REQ-033 Reset release, memory returns 32'h2008_0005 two cycles later -> o_instr_valid=1, o_opcode=6'b001000, o_pc=0; after consume, o_imem_addr=32'h4.
REQ-034 BEQ at PC 32'h10 with imm 16'h0003 -> next address 32'h20 with i_zero=1, and 32'h14 with i_zero=0.
REQ-035 BNE at PC 32'h8 with imm 16'hFFFF, i_zero=0 -> next address 32'h8; o_issue_count increments on each pass.
REQ-036 J at PC 32'h4000_0010 with instr[25:0]=26'h100 -> next address 32'h4000_0400.
REQ-037 i_stall held 3 cycles in ISSUE -> outputs stable and o_imem_req=0 throughout; then opcode 6'h3F consumed -> o_illegal=1 for 1 cycle and next address = PC+4.
REQ-038 Reset asserted while o_imem_req=1 -> o_imem_req=0 the same cycle, o_imem_addr=RESET_PC, o_issue_count=0.
